// File: rtl/rat_intc_pkg.sv
// rat_intc_pkg: shared constants, FSM state type and priority helper for rat_intc.
package rat_intc_pkg;
  localparam int ID_W = 3;
  localparam logic [7:0] PID_MASK_DEF = 8'h30;
  localparam logic [7:0] PID_PEND_DEF = 8'h31;
  localparam logic [7:0] PID_ID_DEF   = 8'h32;
  localparam logic [7:0] PID_ACK_DEF  = 8'h33;
  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_HOLDOFF} state_t;
  // Scanning downward lets the lowest set bit overwrite, giving source 0 top priority.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [7:0] v);
    lowest_idx = '0;
    for (int i = 7; i >= 0; i--) if (v[i]) lowest_idx = ID_W'(i);
  endfunction
endpackage

// File: rtl/rat_intc_edge.sv
// rat_intc_edge: per-source rising-edge detector; define RAT_INTC_SYNC_EN to add a
// 2-flop synchronizer in front of it.
module rat_intc_edge (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_irq,
  output logic o_rise
);
  logic w_in, r_d, r_q;
`ifdef RAT_INTC_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) r_sync <= '0;
    else r_sync <= {r_sync[0], i_irq};
  assign w_in = r_sync[1];
`else
  assign w_in = i_irq;
`endif
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_d <= 1'b0;
      r_q <= 1'b0;
    end else begin
      r_d <= w_in;
      r_q <= r_d;
    end
  assign o_rise = r_d & ~r_q;
endmodule

// File: rtl/rat_intc.sv
// rat_intc: priority interrupt controller driving the RAT MCU INTR line from up to
// eight edge-latched sources; define RAT_INTC_SYNC_EN to synchronize IRQ_IN.
module rat_intc
  import rat_intc_pkg::*;
#(
  parameter int         N_SRC    = 4,
  parameter logic [7:0] PID_MASK = PID_MASK_DEF,
  parameter logic [7:0] PID_PEND = PID_PEND_DEF,
  parameter logic [7:0] PID_ID   = PID_ID_DEF,
  parameter logic [7:0] PID_ACK  = PID_ACK_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_SRC-1:0] IRQ_IN,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic [7:0]       DOUT,
  output logic             INTR
);
  state_t r_state, w_next;
  logic [N_SRC-1:0] r_pend, r_mask, w_rise, w_clr;
  logic [ID_W-1:0] r_cur_id;
  logic [7:0] w_act;
  logic w_ack, w_unused;
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    rat_intc_edge u_edge (.CLK(CLK), .RST_N(RST_N), .i_irq(IRQ_IN[i]), .o_rise(w_rise[i]));
  end
  assign w_act = 8'(r_pend & r_mask);
  assign w_ack = r_state == ST_ASSERT && IO_STRB && PORT_ID == PID_ACK &&
                 OUT_PORT[ID_W-1:0] == r_cur_id;
  assign w_clr = N_SRC'(w_ack) << r_cur_id;
  // A new edge on the source being acknowledged re-sets PEND, so it is serviced again.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_state  <= ST_IDLE;
      r_pend   <= '0;
      r_mask   <= '0;
      r_cur_id <= '0;
    end else begin
      r_state <= w_next;
      r_pend  <= (r_pend & ~w_clr) | w_rise;
      if (IO_STRB && PORT_ID == PID_MASK) r_mask <= OUT_PORT[N_SRC-1:0];
      if (r_state == ST_IDLE && |w_act) r_cur_id <= lowest_idx(w_act);
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = |w_act ? ST_ASSERT : ST_IDLE;
      ST_ASSERT: w_next = w_ack ? ST_HOLDOFF : ST_ASSERT;
      default:   w_next = ST_IDLE;
    endcase
  end
  assign INTR = r_state == ST_ASSERT;
  assign DOUT = PORT_ID == PID_MASK ? 8'(r_mask) :
                PORT_ID == PID_PEND ? 8'(r_pend) :
                PORT_ID == PID_ID   ? 8'(r_cur_id) : 8'h00;
  assign w_unused = ^OUT_PORT;
endmodule

// File: tb/tb_rat_intc.sv
// tb_rat_intc: directed self-checking bench for rat_intc; latency expectations follow
// RAT_INTC_SYNC_EN.
module tb_rat_intc;
`ifdef RAT_INTC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  logic CLK = 1'b0, RST_N = 1'b0, IO_STRB = 1'b0, INTR;
  logic [3:0] IRQ_IN = '0;
  logic [7:0] PORT_ID = '0, OUT_PORT = '0, DOUT, r;
  int n_cmp = 0, n_bad = 0;

  rat_intc dut (.CLK(CLK), .RST_N(RST_N), .IRQ_IN(IRQ_IN), .PORT_ID(PORT_ID),
                .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .DOUT(DOUT), .INTR(INTR));

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] pid, input logic [7:0] d);
    PORT_ID = pid; OUT_PORT = d; IO_STRB = 1'b1;
    tick();
    IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
  endtask

  task automatic rd(input logic [7:0] pid, output logic [7:0] d);
    PORT_ID = pid;
    #1;
    d = DOUT;
    PORT_ID = 8'h00;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; IRQ_IN = '0;
    tick(); tick();
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL rst_intr got %b want 0", INTR); end
    rd(8'h30, r); n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL rst_mask got %h want 00", r); end
    rd(8'h31, r); n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL rst_pend got %h want 00", r); end
    rd(8'h32, r); n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL rst_id got %h want 00", r); end
    RST_N = 1'b1;
    tick();
    wr(8'h30, 8'hFF);
    rd(8'h30, r); n_cmp++; if (r !== 8'h0F) begin n_bad++; $display("FAIL mask_upper got %h want 0f", r); end
    rd(8'h34, r); n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL unmapped_rd got %h want 00", r); end
    wr(8'h30, 8'h00);
  endtask

  task automatic test_mask_gate();
    IRQ_IN[1] = 1'b1; tick(); IRQ_IN[1] = 1'b0;
    repeat (LAT + 1) tick();
    rd(8'h31, r); n_cmp++; if (r !== 8'h02) begin n_bad++; $display("FAIL masked_pend got %h want 02", r); end
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL masked_intr got %b want 0", INTR); end
    wr(8'h30, 8'h02);
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL unmask_early got %b want 0", INTR); end
    tick();
    n_cmp++; if (INTR !== 1'b1) begin n_bad++; $display("FAIL unmask_intr got %b want 1", INTR); end
    rd(8'h32, r); n_cmp++; if (r !== 8'h01) begin n_bad++; $display("FAIL unmask_id got %h want 01", r); end
    wr(8'h33, 8'h01);
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL ack1_intr got %b want 0", INTR); end
    tick(); tick();
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL ack1_idle got %b want 0", INTR); end
    rd(8'h31, r); n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL ack1_pend got %h want 00", r); end
  endtask

  task automatic test_latency();
    wr(8'h30, 8'h0F);
    IRQ_IN[2] = 1'b1;
    for (int j = 0; j < LAT; j++) begin
      tick();
      n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL lat_early%0d got %b want 0", j, INTR); end
    end
    tick();
    n_cmp++; if (INTR !== 1'b1) begin n_bad++; $display("FAIL lat_intr got %b want 1", INTR); end
    rd(8'h32, r); n_cmp++; if (r !== 8'h02) begin n_bad++; $display("FAIL lat_id got %h want 02", r); end
  endtask

  task automatic test_bad_ack();
    wr(8'h33, 8'h01);
    n_cmp++; if (INTR !== 1'b1) begin n_bad++; $display("FAIL badack_intr got %b want 1", INTR); end
    rd(8'h31, r); n_cmp++; if (r !== 8'h04) begin n_bad++; $display("FAIL badack_pend got %h want 04", r); end
    rd(8'h32, r); n_cmp++; if (r !== 8'h02) begin n_bad++; $display("FAIL badack_id got %h want 02", r); end
    wr(8'h33, 8'h02);
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL ack2_intr got %b want 0", INTR); end
    IRQ_IN[2] = 1'b0;
    repeat (3) tick();
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL ack2_idle got %b want 0", INTR); end
    rd(8'h31, r); n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL ack2_pend got %h want 00", r); end
  endtask

  task automatic test_priority();
    IRQ_IN = 4'b1010;
    repeat (LAT + 1) tick();
    IRQ_IN = '0;
    n_cmp++; if (INTR !== 1'b1) begin n_bad++; $display("FAIL prio_intr got %b want 1", INTR); end
    rd(8'h32, r); n_cmp++; if (r !== 8'h01) begin n_bad++; $display("FAIL prio_id1 got %h want 01", r); end
    wr(8'h33, 8'h01);
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL prio_holdoff got %b want 0", INTR); end
    tick();
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL prio_idle got %b want 0", INTR); end
    tick();
    n_cmp++; if (INTR !== 1'b1) begin n_bad++; $display("FAIL prio_reassert got %b want 1", INTR); end
    rd(8'h32, r); n_cmp++; if (r !== 8'h03) begin n_bad++; $display("FAIL prio_id3 got %h want 03", r); end
    wr(8'h33, 8'h03);
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL prio_ack3 got %b want 0", INTR); end
    tick(); tick();
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL prio_done got %b want 0", INTR); end
    rd(8'h31, r); n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL prio_pend got %h want 00", r); end
  endtask

  task automatic test_set_wins();
    IRQ_IN[0] = 1'b1;
    repeat (LAT + 1) tick();
    rd(8'h32, r); n_cmp++; if (r !== 8'h00 || INTR !== 1'b1) begin n_bad++; $display("FAIL sw_first got id %h intr %b want 00 1", r, INTR); end
    IRQ_IN[0] = 1'b0;
    repeat (LAT + 2) tick();
    IRQ_IN[0] = 1'b1;
    repeat (LAT - 1) tick();
    wr(8'h33, 8'h00);
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL sw_holdoff got %b want 0", INTR); end
    rd(8'h31, r); n_cmp++; if (r !== 8'h01) begin n_bad++; $display("FAIL sw_pend got %h want 01", r); end
    tick(); tick();
    n_cmp++; if (INTR !== 1'b1) begin n_bad++; $display("FAIL sw_reassert got %b want 1", INTR); end
    IRQ_IN[0] = 1'b0;
    wr(8'h33, 8'h00);
    repeat (LAT + 2) tick();
    rd(8'h31, r); n_cmp++; if (r !== 8'h00 || INTR !== 1'b0) begin n_bad++; $display("FAIL sw_done got pend %h intr %b want 00 0", r, INTR); end
  endtask

  task automatic test_reset_mid();
    wr(8'h30, 8'h02);
    IRQ_IN[1] = 1'b1;
    repeat (LAT + 1) tick();
    n_cmp++; if (INTR !== 1'b1) begin n_bad++; $display("FAIL rm_pre got %b want 1", INTR); end
    RST_N = 1'b0;
    #1;
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL rm_intr got %b want 0", INTR); end
    rd(8'h30, r); n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL rm_mask got %h want 00", r); end
    rd(8'h31, r); n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL rm_pend got %h want 00", r); end
    IRQ_IN = '0;
    tick();
    RST_N = 1'b1;
    repeat (6) tick();
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL rm_post got %b want 0", INTR); end
    wr(8'h30, 8'h02);
    repeat (3) tick();
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL rm_noedge got %b want 0", INTR); end
    IRQ_IN[1] = 1'b1;
    repeat (LAT + 1) tick();
    n_cmp++; if (INTR !== 1'b1) begin n_bad++; $display("FAIL rm_newedge got %b want 1", INTR); end
    IRQ_IN = '0;
    wr(8'h33, 8'h01);
    n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL rm_ack got %b want 0", INTR); end
  endtask

  initial begin
    test_reset();
    test_mask_gate();
    test_latency();
    test_bad_ack();
    test_priority();
    test_set_wins();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
